// File: rtl/instruction_fetch_sequencer.sv
// Fetch stage: reads 16-bit little-endian instructions a byte at a time
// through the address register file's PC and hands them to decode.
module instruction_fetch_sequencer (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        Start,
   input  logic [7:0]  MemData,
   input  logic        Redirect,
   input  logic [15:0] Target,
   input  logic        InstrReady,
   output logic [15:0] ARF_I,
   output logic [1:0]  ARF_FunSel,
   output logic [2:0]  ARF_RegSel,
   output logic [1:0]  ARF_OutDSel,
   output logic        MemRead,
   output logic [15:0] Instr,
   output logic        InstrValid,
   output logic [15:0] FetchCount
);

   typedef enum logic [1:0] {
      IDLE,
      FETCH_LO,
      FETCH_HI,
      VALID
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] instr_q, instr_d;
   logic [15:0] count_q, count_d;
   logic        fetching;
   logic        pc_we;

   always_comb begin
      state_d = state_q;
      instr_d = instr_q;
      count_d = count_q;
      unique case (state_q)
         IDLE: begin
            if (Start) state_d = FETCH_LO;
         end
         FETCH_LO: begin
            if (Redirect) begin
               state_d = FETCH_LO;
            end else begin
               instr_d[7:0] = MemData;
               state_d      = FETCH_HI;
            end
         end
         FETCH_HI: begin
            if (Redirect) begin
               state_d = FETCH_LO;
            end else begin
               instr_d[15:8] = MemData;
               state_d       = VALID;
            end
         end
         VALID: begin
            // A handshake still counts when a redirect lands on it.
            if (InstrReady) begin
               count_d = count_q + 16'd1;
               state_d = FETCH_LO;
            end
            if (Redirect) state_d = FETCH_LO;
         end
      endcase
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state_q <= IDLE;
         instr_q <= 16'h0000;
         count_q <= 16'h0000;
      end else begin
         state_q <= state_d;
         instr_q <= instr_d;
         count_q <= count_d;
      end
   end

   assign fetching = (state_q == FETCH_LO) || (state_q == FETCH_HI);

   // Gate PC writes with reset so an edge during reset leaves PC alone.
   assign pc_we = Reset && (Redirect || fetching);

   assign ARF_I       = Target;
   assign ARF_RegSel  = {pc_we, 2'b00};
   assign ARF_FunSel  = (Reset && Redirect) ? 2'b10 : 2'b01;
   assign ARF_OutDSel = 2'b00;
   assign MemRead     = fetching && !Redirect;
   assign Instr       = instr_q;
   assign InstrValid  = (state_q == VALID);
   assign FetchCount  = count_q;

endmodule

// File: doc/instruction_fetch_sequencer.md
# instruction_fetch_sequencer

Fetch stage placed directly upstream of the address register file. It drives the file's PC control and D-port select to read 16-bit instructions from the byte-wide memory, two bytes per instruction, little-endian. It increments PC after each byte, assembles the instruction and hands it to the decode/execute stage with a valid/ready handshake. It also accepts PC redirects (branches and boot vector) from execute.

## Interface
- No parameters; all widths are fixed.
- Clock  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-low; 0 forces reset state immediately.
- Start  in  1  level; leaves IDLE and begins fetching.
- MemData  in  8  read data from memory at address OutD; valid combinationally in the same cycle.
- Redirect  in  1  load PC with Target this cycle.
- Target  in  16  new PC value, used only when Redirect=1.
- InstrReady  in  1  consumer accepts Instr.
- ARF_I  out  16  data to the address register file I[15:0]; equals Target.
- ARF_FunSel  out  2  register function: 01 increment, 10 load.
- ARF_RegSel  out  3  register enables; bit2=PC, bit1=SP, bit0=AR. Only 100 or 000 are ever driven.
- ARF_OutDSel  out  2  constant 00 (PC on OutD).
- MemRead  out  1  memory read strobe.
- Instr  out  16  assembled instruction.
- InstrValid  out  1  Instr is valid.
- FetchCount  out  16  number of instructions accepted since reset.

## Operation
- States: IDLE, FETCH_LO, FETCH_HI, VALID. Registered state; outputs decoded from state and Redirect.
- Default outputs: ARF_RegSel=000, ARF_FunSel=01, MemRead=0, InstrValid=0.
- IDLE
  - Go to FETCH_LO when Start=1.
  - Redirect=1 loads PC with Target (RegSel=100, FunSel=10). The block stays in IDLE unless Start=1 in the same cycle. This is the boot-vector path.
- FETCH_LO
  - MemRead=1, RegSel=100, FunSel=01 (PC++).
  - Instr[7:0] <= MemData at the edge.
  - Next state: FETCH_HI.
- FETCH_HI
  - Same controls as FETCH_LO; Instr[15:8] <= MemData.
  - Next state: VALID.
- VALID
  - InstrValid=1; Instr held stable; PC not touched.
  - InstrReady=1: handshake completes, FetchCount++, next state FETCH_LO.
  - Otherwise the block stays in VALID indefinitely.
- Redirect in FETCH_LO, FETCH_HI or VALID (highest priority)
  - RegSel=100, FunSel=10, MemRead=0; no byte is captured.
  - Next state: FETCH_LO. Any partial instruction is discarded.
- Redirect together with InstrReady in VALID: the handshake still completes (FetchCount++), PC loads Target, and the next state is FETCH_LO.
- Start is ignored outside IDLE. Once started, the block never returns to IDLE except through Reset.
- FetchCount wraps 0xFFFF -> 0x0000. PC wrap is owned by the register file (16-bit modular).
- Reset (asynchronous, any state): state=IDLE, Instr=0x0000, InstrValid=0, FetchCount=0, MemRead=0, RegSel=000, FunSel=01, OutDSel=00, ARF_I=Target.
- Reset does not alter PC, because the file has no reset. Software boots via Redirect in IDLE.
- Reset asserted mid-fetch: the partial instruction is lost and no PC update occurs on that edge.

## Timing
- Fetch latency: InstrValid rises 2 edges after the edge that enters FETCH_LO.
- Throughput with InstrReady held 1: one instruction per 3 cycles.
- PC increments on exactly two edges per instruction. It is loaded on the edge where Redirect=1 (any state).
- After Redirect, the first byte is read from Target on the next cycle.
- MemRead is high exactly in the FETCH_LO and FETCH_HI cycles without Redirect.
- InstrValid never drops without a handshake, except on Redirect or Reset.

## Test plan
- Boot: Reset low then high, Redirect=1, Target=0x0040 in IDLE. Then Start=1 with memory[0x40]=0x34, [0x41]=0x12 and InstrReady=1 -> Instr=0x1234 and InstrValid=1 on the 3rd cycle after Start; PC=0x0042; FetchCount=1 after the handshake.
- Backpressure: InstrReady=0 for 5 cycles in VALID -> Instr and PC stable and MemRead=0. InstrReady=1 -> next fetch starts from the next PC.
- Redirect during FETCH_HI at PC=0x0011 with Target=0x0100 -> no Instr[15:8] capture, PC=0x0100 next edge, following Instr taken from bytes 0x0100/0x0101.
- Simultaneous InstrReady and Redirect in VALID -> FetchCount increments, PC=Target, state FETCH_LO.
- Asynchronous Reset low mid-FETCH_LO -> InstrValid=0, Instr=0, FetchCount=0 immediately, RegSel=000; PC unchanged.
- FetchCount preloaded by running 65536 handshakes -> count wraps to 0x0000. PC fetch across 0xFFFF->0x0000 assembles bytes [0xFFFF] and [0x0000].
